// File: rtl/rs_age_queue.sv
// rs_age_queue
//   Reservation station for the ALU/branch pipe. Holds issued uops until both
//   source operands are available, snooping CDB_N result-broadcast channels,
//   and offers the oldest ready entry to the execution unit over valid/ready.
//
// Ports
//   clk, rst      : clock; synchronous active-high reset
//   rdy           : global enable; low freezes all state
//   flush         : ROB clear; empties the station at the next edge
//   in_valid/in_ready        : issue handshake
//   in_op, in_pc             : opaque opcode bundle and instruction address
//   in_v1/in_v2              : source values (valid when matching dep is 0)
//   in_dep1/in_dep2          : source pending flags
//   in_q1/in_q2              : producer ROB tags for pending sources
//   in_dst                   : own ROB tag
//   cdb_valid/tag/value      : CDB_N flattened broadcast channels
//   out_valid/out_ready      : dispatch handshake
//   out_op/pc/v1/v2/dst      : payload of the selected (oldest ready) entry
//   count                    : number of occupied entries
module rs_age_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4,
  parameter int XLEN  = 32,
  parameter int OP_W  = 11,
  parameter int CDB_N = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OP_W-1:0]          in_op,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_v1,
  input  logic [XLEN-1:0]          in_v2,
  input  logic                     in_dep1,
  input  logic                     in_dep2,
  input  logic [TAG_W-1:0]         in_q1,
  input  logic [TAG_W-1:0]         in_q2,
  input  logic [TAG_W-1:0]         in_dst,
  input  logic [CDB_N-1:0]         cdb_valid,
  input  logic [CDB_N*TAG_W-1:0]   cdb_tag,
  input  logic [CDB_N*XLEN-1:0]    cdb_value,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP_W-1:0]          out_op,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_v1,
  output logic [XLEN-1:0]          out_v2,
  output logic [TAG_W-1:0]         out_dst,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Per-entry state
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] r_dep1;
  logic [DEPTH-1:0] r_dep2;
  logic [OP_W-1:0]  r_op   [DEPTH];
  logic [XLEN-1:0]  r_pc   [DEPTH];
  logic [XLEN-1:0]  r_v1   [DEPTH];
  logic [XLEN-1:0]  r_v2   [DEPTH];
  logic [TAG_W-1:0] r_q1   [DEPTH];
  logic [TAG_W-1:0] r_q2   [DEPTH];
  logic [TAG_W-1:0] r_dst  [DEPTH];
  // r_older[k][j] set: entry j is older than entry k
  logic [DEPTH-1:0] r_older[DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_sel;
  logic [DEPTH-1:0] w_alloc;
  logic             w_alloc_found;
  logic [DEPTH-1:0] w_disp_vec;
  logic [DEPTH-1:0] w_keep;
  logic [DEPTH-1:0] w_wk1;
  logic [DEPTH-1:0] w_wk2;
  logic [XLEN-1:0]  w_wv1  [DEPTH];
  logic [XLEN-1:0]  w_wv2  [DEPTH];
  logic             w_in_hit1;
  logic             w_in_hit2;
  logic [XLEN-1:0]  w_in_val1;
  logic [XLEN-1:0]  w_in_val2;
  logic             w_acc;
  logic             w_disp;

  // Tag lookup across all channels; the lowest matching channel wins.
  // Returns {hit, value}.
  function automatic logic [XLEN:0] f_snoop(
    input logic [CDB_N-1:0]       vld,
    input logic [CDB_N*TAG_W-1:0] tags,
    input logic [CDB_N*XLEN-1:0]  vals,
    input logic [TAG_W-1:0]       tag
  );
    logic            hit;
    logic [XLEN-1:0] val;
    hit = 1'b0;
    val = '0;
    for (int unsigned c = 0; c < CDB_N; c++) begin
      if (!hit && vld[c] && (tags[c*TAG_W +: TAG_W] == tag)) begin
        hit = 1'b1;
        val = vals[c*XLEN +: XLEN];
      end
    end
    return {hit, val};
  endfunction

  // Wakeup matches for stored entries and for the incoming uop
  always_comb begin
    logic [XLEN:0] t;
    w_wk1 = '0;
    w_wk2 = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      t        = f_snoop(cdb_valid, cdb_tag, cdb_value, r_q1[k]);
      w_wk1[k] = t[XLEN];
      w_wv1[k] = t[XLEN-1:0];
      t        = f_snoop(cdb_valid, cdb_tag, cdb_value, r_q2[k]);
      w_wk2[k] = t[XLEN];
      w_wv2[k] = t[XLEN-1:0];
    end
    t         = f_snoop(cdb_valid, cdb_tag, cdb_value, in_q1);
    w_in_hit1 = t[XLEN];
    w_in_val1 = t[XLEN-1:0];
    t         = f_snoop(cdb_valid, cdb_tag, cdb_value, in_q2);
    w_in_hit2 = t[XLEN];
    w_in_val2 = t[XLEN-1:0];
  end

  // Ready is based on registered state only, so an entry waking this cycle
  // becomes eligible next cycle.
  assign w_ready = r_busy & ~r_dep1 & ~r_dep2;

  // Oldest-ready select: k wins when none of the entries older than k is ready.
  // Ages are a total order over busy entries, so w_sel is one-hot or zero.
  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_sel[k] = w_ready[k] && ((r_older[k] & w_ready) == '0);
    end
  end

  // Lowest-index free slot
  always_comb begin
    w_alloc       = '0;
    w_alloc_found = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!w_alloc_found && !r_busy[k]) begin
        w_alloc[k]    = 1'b1;
        w_alloc_found = 1'b1;
      end
    end
  end

  // One-hot OR mux; an empty selection drives zeros
  always_comb begin
    out_op  = '0;
    out_pc  = '0;
    out_v1  = '0;
    out_v2  = '0;
    out_dst = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_sel[k]) begin
        out_op  = out_op  | r_op[k];
        out_pc  = out_pc  | r_pc[k];
        out_v1  = out_v1  | r_v1[k];
        out_v2  = out_v2  | r_v2[k];
        out_dst = out_dst | r_dst[k];
      end
    end
  end

  assign out_valid  = rdy && (w_ready != '0);
  // Deliberately ignores a same-cycle dispatch: no out_ready -> in_ready path
  assign in_ready   = rdy && (r_count < CW'(DEPTH));
  assign w_acc      = in_valid && in_ready;
  assign w_disp     = out_valid && out_ready;
  assign w_disp_vec = w_disp ? w_sel : '0;
  // Entries that remain resident past this edge; a new entry is younger than all
  assign w_keep     = r_busy & ~w_disp_vec;
  assign count      = r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_busy  <= '0;
      r_dep1  <= '0;
      r_dep2  <= '0;
      r_count <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        r_older[k] <= '0;
      end
    end else if (rdy) begin
      r_count <= r_count + CW'(w_acc) - CW'(w_disp);
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_acc && w_alloc[k]) begin
          r_busy[k]  <= 1'b1;
          r_op[k]    <= in_op;
          r_pc[k]    <= in_pc;
          r_dst[k]   <= in_dst;
          r_q1[k]    <= in_q1;
          r_q2[k]    <= in_q2;
          r_dep1[k]  <= in_dep1 && !w_in_hit1;
          r_dep2[k]  <= in_dep2 && !w_in_hit2;
          r_v1[k]    <= (in_dep1 && w_in_hit1) ? w_in_val1 : in_v1;
          r_v2[k]    <= (in_dep2 && w_in_hit2) ? w_in_val2 : in_v2;
          r_older[k] <= w_keep;
        end else begin
          if (w_disp_vec[k]) begin
            r_busy[k] <= 1'b0;
          end
          if (r_busy[k] && r_dep1[k] && w_wk1[k]) begin
            r_v1[k]   <= w_wv1[k];
            r_dep1[k] <= 1'b0;
          end
          if (r_busy[k] && r_dep2[k] && w_wk2[k]) begin
            r_v2[k]   <= w_wv2[k];
            r_dep2[k] <= 1'b0;
          end
          // Every resident entry is older than the newcomer
          if (w_acc) begin
            r_older[k] <= r_older[k] & ~w_alloc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rs_age_queue.sv
// tb_rs_age_queue
//   Bench for rs_age_queue. A behavioural model keeps resident uops in a
//   queue in issue order; the oldest ready uop is simply the first one in the
//   queue with no pending source. Directed scenarios pin literal values, then
//   a randomized phase runs against the same model.
module tb_rs_age_queue;

  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int XLEN  = 32;
  localparam int OP_W  = 11;
  localparam int CDB_N = 2;

  logic                   clk = 1'b0;
  logic                   rst, rdy, flush;
  logic                   in_valid, in_ready;
  logic [OP_W-1:0]        in_op;
  logic [XLEN-1:0]        in_pc, in_v1, in_v2;
  logic                   in_dep1, in_dep2;
  logic [TAG_W-1:0]       in_q1, in_q2, in_dst;
  logic [CDB_N-1:0]       cdb_valid;
  logic [CDB_N*TAG_W-1:0] cdb_tag;
  logic [CDB_N*XLEN-1:0]  cdb_value;
  logic                   out_valid, out_ready;
  logic [OP_W-1:0]        out_op;
  logic [XLEN-1:0]        out_pc, out_v1, out_v2;
  logic [TAG_W-1:0]       out_dst;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  rs_age_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .XLEN(XLEN), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
    .in_v1(in_v1), .in_v2(in_v2), .in_dep1(in_dep1), .in_dep2(in_dep2),
    .in_q1(in_q1), .in_q2(in_q2), .in_dst(in_dst),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op), .out_pc(out_pc),
    .out_v1(out_v1), .out_v2(out_v2), .out_dst(out_dst), .count(count)
  );

  typedef struct {
    logic [OP_W-1:0]  op;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic             d1;
    logic             d2;
    logic [TAG_W-1:0] q1;
    logic [TAG_W-1:0] q2;
    logic [TAG_W-1:0] dst;
  } ent_t;

  ent_t mq[$];   // resident uops, oldest first
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_find();
    for (int i = 0; i < mq.size(); i++) begin
      if (!mq[i].d1 && !mq[i].d2) return i;
    end
    return -1;
  endfunction

  // First channel carrying the tag supplies the value
  task automatic m_snoop(input logic [TAG_W-1:0] tag, output logic hit, output logic [XLEN-1:0] val);
    hit = 1'b0;
    val = '0;
    for (int c = 0; c < CDB_N; c++) begin
      if (!hit && cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag) begin
        hit = 1'b1;
        val = cdb_value[c*XLEN +: XLEN];
      end
    end
  endtask

  // Compare this cycle's outputs against the model, then advance both across
  // one clock edge. Returns at posedge + 1.
  task automatic tick();
    int              s;
    logic            ev, acc, hit;
    logic [XLEN-1:0] val;
    ent_t            e;
    @(negedge clk);
    s  = m_find();
    ev = rdy && (s >= 0);
    chk("in_ready",  64'(in_ready),  64'(rdy && (mq.size() < DEPTH)));
    chk("count",     64'(count),     64'(mq.size()));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      chk("out_op",  64'(out_op),  64'(mq[s].op));
      chk("out_pc",  64'(out_pc),  64'(mq[s].pc));
      chk("out_v1",  64'(out_v1),  64'(mq[s].v1));
      chk("out_v2",  64'(out_v2),  64'(mq[s].v2));
      chk("out_dst", 64'(out_dst), 64'(mq[s].dst));
    end
    if (rst || flush) begin
      mq.delete();
    end else if (rdy) begin
      acc = in_valid && (mq.size() < DEPTH);
      for (int i = 0; i < mq.size(); i++) begin
        e = mq[i];
        if (e.d1) begin
          m_snoop(e.q1, hit, val);
          if (hit) begin e.v1 = val; e.d1 = 1'b0; end
        end
        if (e.d2) begin
          m_snoop(e.q2, hit, val);
          if (hit) begin e.v2 = val; e.d2 = 1'b0; end
        end
        mq[i] = e;
      end
      if (ev && out_ready) mq.delete(s);
      if (acc) begin
        e.op = in_op; e.pc = in_pc; e.dst = in_dst;
        e.q1 = in_q1; e.q2 = in_q2;
        e.v1 = in_v1; e.v2 = in_v2;
        e.d1 = in_dep1; e.d2 = in_dep2;
        if (in_dep1) begin
          m_snoop(in_q1, hit, val);
          if (hit) begin e.v1 = val; e.d1 = 1'b0; end
        end
        if (in_dep2) begin
          m_snoop(in_q2, hit, val);
          if (hit) begin e.v2 = val; e.d2 = 1'b0; end
        end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [TAG_W-1:0] dst, input logic [XLEN-1:0] v1,
                       input logic [XLEN-1:0] v2, input logic d1, input logic [TAG_W-1:0] q1);
    in_valid = 1'b1;
    in_op    = 11'(dst) + 11'h100;
    in_pc    = 32'h1000 + 32'(dst) * 4;
    in_dst   = dst;
    in_v1    = v1;
    in_v2    = v2;
    in_dep1  = d1;
    in_dep2  = 1'b0;
    in_q1    = q1;
    in_q2    = '0;
  endtask

  task automatic bcast(input int ch, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] val);
    cdb_valid[ch]              = 1'b1;
    cdb_tag[ch*TAG_W +: TAG_W] = tag;
    cdb_value[ch*XLEN +: XLEN] = val;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_op = '0; in_pc = '0; in_v1 = '0; in_v2 = '0;
    in_dep1 = 1'b0; in_dep2 = 1'b0; in_q1 = '0; in_q2 = '0; in_dst = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();

    // Reset state
    #1;
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_v1",    64'(out_v1),    64'd0);
    chk("rst_out_dst",   64'(out_dst),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);

    // 1: ready-at-issue, one cycle to dispatch
    out_ready = 1'b1;
    issue(4'd9, 32'd5, 32'd7, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_v1",    64'(out_v1),    64'd5);
    chk("t1_v2",    64'(out_v2),    64'd7);
    chk("t1_dst",   64'(out_dst),   64'd9);
    chk("t1_count", 64'(count),     64'd1);
    tick();
    chk("t1_count_after", 64'(count), 64'd0);

    // 2: younger ready entry passes an older waiting one
    issue(4'd1, 32'd0, 32'd11, 1'b1, 4'd3);
    tick();
    issue(4'd2, 32'd1, 32'd2, 1'b0, 4'd0);
    tick();
    in_valid = 1'b0;
    bcast(1, 4'd3, 32'h10);
    #1;
    chk("t2_first_dst", 64'(out_dst), 64'd2);
    tick();
    cdb_valid = '0;
    #1;
    chk("t2_second_valid", 64'(out_valid), 64'd1);
    chk("t2_second_dst",   64'(out_dst),   64'd1);
    chk("t2_second_v1",    64'(out_v1),    64'h10);
    tick();

    // 3: age beats index when both wake together
    out_ready = 1'b0;
    issue(4'd3, 32'd3, 32'd3, 1'b0, 4'd0);
    tick();
    issue(4'd4, 32'd0, 32'd4, 1'b1, 4'd2);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    issue(4'd5, 32'd0, 32'd5, 1'b1, 4'd2);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    bcast(0, 4'd2, 32'h22);
    #1;
    chk("t3_none_ready", 64'(out_valid), 64'd0);
    tick();
    cdb_valid = '0;
    #1;
    chk("t3_old_dst", 64'(out_dst), 64'd4);
    chk("t3_old_v1",  64'(out_v1),  64'h22);
    tick();
    chk("t3_young_dst", 64'(out_dst), 64'd5);
    tick();
    chk("t3_empty", 64'(count), 64'd0);

    // 4: same-cycle forwarding at issue
    out_ready = 1'b0;
    issue(4'd6, 32'd0, 32'd6, 1'b1, 4'd5);
    bcast(0, 4'd5, 32'hAB);
    tick();
    cdb_valid = '0;
    in_valid = 1'b0;
    #1;
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_v1",    64'(out_v1),    64'hAB);
    out_ready = 1'b1;
    tick();

    // 5: full, one dispatch frees a slot, flush beats a same-cycle accept
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      issue(4'(i), 32'(i), 32'(i + 100), 1'b0, 4'd0);
      tick();
    end
    #1;
    chk("t5_full_count", 64'(count),    64'd8);
    chk("t5_full_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    chk("t5_count7", 64'(count),    64'd7);
    chk("t5_ready",  64'(in_ready), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t5_flush_count", 64'(count),     64'd0);
    chk("t5_flush_valid", 64'(out_valid), 64'd0);

    // 6: rdy low freezes state and misses the broadcast
    out_ready = 1'b1;
    issue(4'd7, 32'd0, 32'd7, 1'b1, 4'd6);
    tick();
    in_valid = 1'b0;
    rdy = 1'b0;
    bcast(0, 4'd6, 32'h66);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t6_in_ready",  64'(in_ready),  64'd0);
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      tick();
    end
    rdy = 1'b1;
    cdb_valid = '0;
    #1;
    chk("t6_count", 64'(count),     64'd1);
    chk("t6_still", 64'(out_valid), 64'd0);
    bcast(0, 4'd6, 32'h66);
    tick();
    cdb_valid = '0;
    #1;
    chk("t6_wake_v1", 64'(out_v1), 64'h66);
    tick();

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst       = ($urandom_range(0, 299) == 0);
      flush     = ($urandom_range(0, 79) == 0);
      rdy       = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 9) < 6);
      out_ready = ($urandom_range(0, 9) < 6);
      in_op     = 11'($urandom_range(0, 2047));
      in_pc     = $urandom;
      in_v1     = $urandom;
      in_v2     = $urandom;
      in_dep1   = ($urandom_range(0, 1) == 1);
      in_dep2   = ($urandom_range(0, 2) == 0);
      in_q1     = 4'($urandom_range(0, 3));
      in_q2     = 4'($urandom_range(0, 3));
      in_dst    = 4'($urandom_range(0, 15));
      for (int c = 0; c < CDB_N; c++) begin
        cdb_valid[c]              = ($urandom_range(0, 2) == 0);
        cdb_tag[c*TAG_W +: TAG_W] = 4'($urandom_range(0, 3));
        cdb_value[c*XLEN +: XLEN] = $urandom;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
